// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between instruction fetch and data access.
// Data normally wins contention; a streak counter caps consecutive data grants while fetch waits.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_DSTRK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned SW = $clog2(MAX_DSTRK + 1);
  localparam logic [SW-1:0] MAXV = SW'(MAX_DSTRK);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2
  } rv_tag_t;

  rv_tag_t       r_rv_tag;
  rv_tag_t       w_rv_tag_nxt;
  logic [SW-1:0] r_dstrk;
  logic [SW-1:0] w_dstrk_nxt;
  logic          w_if_gnt;
  logic          w_dm_gnt;

  // Grants depend only on the request bits and the streak, never on addresses.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (dm_req && (!if_req || (r_dstrk < MAXV))) begin
      w_dm_gnt = 1'b1;
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end
  end

  always_comb begin
    w_dstrk_nxt  = '0;
    w_rv_tag_nxt = TAG_NONE;
    if (w_dm_gnt && if_req) begin
      w_dstrk_nxt = (r_dstrk == MAXV) ? r_dstrk : r_dstrk + 1'b1;
    end
    if (w_if_gnt) begin
      w_rv_tag_nxt = TAG_IF;
    end else if (w_dm_gnt && !dm_we) begin
      w_rv_tag_nxt = TAG_DM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rv_tag <= TAG_NONE;
      r_dstrk  <= '0;
    end else begin
      r_rv_tag <= w_rv_tag_nxt;
      r_dstrk  <= w_dstrk_nxt;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign mem_addr  = w_if_gnt ? if_addr : dm_addr;
  assign mem_wdata = dm_wdata;
  assign mem_we    = w_dm_gnt & dm_we;

  assign if_rvalid = (r_rv_tag == TAG_IF);
  assign dm_rvalid = (r_rv_tag == TAG_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  assign busy = w_if_gnt | w_dm_gnt | if_rvalid | dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: write-first memory environment plus a
// cycle-level reference model of grants, streak limit and tagged read return.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_DSTRK = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_DSTRK(MAX_DSTRK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Synchronous write-first memory attached to the port.
  logic [DATA_W-1:0] env_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      mem_rdata         <= mem_wdata;
    end else begin
      mem_rdata <= env_mem[mem_addr];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  int                ref_streak;
  int                ref_tag;      // 0 none, 1 fetch, 2 data
  logic [DATA_W-1:0] ref_data;
  bit                last_ig, last_dg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_cycle(input bit ireq, input logic [ADDR_W-1:0] ia,
                             input bit dreq, input bit dwe,
                             input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
    bit eig, edg;
    @(posedge clk); #1;
    if_req   = ireq;
    if_addr  = ireq ? ia : 'x;
    dm_req   = dreq;
    dm_we    = dreq & dwe;
    dm_addr  = dreq ? da : 'x;
    dm_wdata = dwd;
    @(negedge clk);
    eig = ireq && (!dreq || ref_streak >= MAX_DSTRK);
    edg = dreq && !eig;
    check_eq("if_gnt", if_gnt, eig);
    check_eq("dm_gnt", dm_gnt, edg);
    check_eq("mem_we", mem_we, edg && dwe);
    check_eq("mem_wdata", mem_wdata, dwd);
    if (eig) check_eq("mem_addr_if", mem_addr, ia);
    if (edg) check_eq("mem_addr_dm", mem_addr, da);
    check_eq("if_rvalid", if_rvalid, ref_tag == 1);
    check_eq("dm_rvalid", dm_rvalid, ref_tag == 2);
    check_eq("if_rdata", if_rdata, (ref_tag == 1) ? ref_data : '0);
    check_eq("dm_rdata", dm_rdata, (ref_tag == 2) ? ref_data : '0);
    check_eq("busy", busy, eig || edg || ref_tag != 0);
    // advance the model across the coming edge
    ref_tag = eig ? 1 : ((edg && !dwe) ? 2 : 0);
    if (eig) ref_data = ref_mem[ia];
    else if (edg && !dwe) ref_data = ref_mem[da];
    if (edg && dwe) ref_mem[da] = dwd;
    if (edg && ireq) ref_streak = (ref_streak < MAX_DSTRK) ? ref_streak + 1 : MAX_DSTRK;
    else ref_streak = 0;
    last_ig = eig;
    last_dg = edg;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset  = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    #1;
    check_eq("rst_if_rvalid", if_rvalid, 0);
    check_eq("rst_dm_rvalid", dm_rvalid, 0);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_we", mem_we, 0);
    ref_tag    = 0;
    ref_streak = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  bit                rq_if, rq_dm, rq_we;
  logic [ADDR_W-1:0] rq_ia, rq_da;
  logic [DATA_W-1:0] rq_wd;
  bit                pat3 [6] = '{1, 1, 1, 1, 0, 1};
  bit                pat4 [5] = '{1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ref_mem[i] = $urandom;
      env_mem[i] = ref_mem[i];
    end
    ref_tag = 0; ref_streak = 0; ref_data = '0;
    @(negedge clk);
    check_eq("init_if_gnt", if_gnt, 0);
    check_eq("init_if_rvalid", if_rvalid, 0);
    check_eq("init_dm_rvalid", dm_rvalid, 0);
    check_eq("init_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // fetch alone
    drive_cycle(1, 16'h0010, 0, 0, '0, '0);
    check_eq("s1_mem_addr", mem_addr, 16'h0010);
    drive_cycle(0, '0, 0, 0, '0, '0);
    check_eq("s1_if_rdata", if_rdata, ref_mem[16'h0010]);

    // write then read back
    drive_cycle(0, '0, 1, 1, 16'h0100, 32'hDEADBEEF);
    drive_cycle(0, '0, 1, 0, 16'h0100, 32'h0);
    check_eq("s2_no_wr_rvalid", dm_rvalid, 0);
    drive_cycle(0, '0, 0, 0, '0, '0);
    check_eq("s2_rdata", dm_rdata, 32'hDEADBEEF);

    // sustained contention: four data grants, then fetch
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 16'h0020, 1, 0, 16'h0030 + i[15:0], '0);
      check_eq("s3_dm_gnt", dm_gnt, pat3[i]);
    end
    drive_cycle(0, '0, 0, 0, '0, '0);

    // fetch withdraws after two data grants, streak restarts
    drive_cycle(1, 16'h0040, 1, 0, 16'h0050, '0);
    drive_cycle(1, 16'h0040, 1, 0, 16'h0051, '0);
    drive_cycle(0, '0, 1, 0, 16'h0052, '0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 16'h0041, 1, 1, 16'h0060 + i[15:0], $urandom);
      check_eq("s4_dm_gnt", dm_gnt, pat4[i]);
    end

    // reset with a data read in flight
    drive_cycle(0, '0, 1, 0, 16'h0070, '0);
    do_reset();
    drive_cycle(0, '0, 0, 0, '0, '0);
    check_eq("s5_dm_rvalid", dm_rvalid, 0);
    drive_cycle(1, 16'h0010, 0, 0, '0, '0);
    check_eq("s5_if_gnt", if_gnt, 1);
    drive_cycle(0, '0, 0, 0, '0, '0);

    // idle with unknown addresses
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 'x, 0, 0, 'x, $urandom);
      check_eq("s6_busy", busy, 0);
    end

    // randomized traffic over a small address window
    rq_if = 0; rq_dm = 0; rq_we = 0; rq_ia = '0; rq_da = '0; rq_wd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!rq_if && $urandom_range(0, 2) != 0) begin
        rq_if = 1; rq_ia = ADDR_W'($urandom_range(0, 31));
      end else if (rq_if && $urandom_range(0, 15) == 0) begin
        rq_if = 0;
      end
      if (!rq_dm && $urandom_range(0, 3) != 0) begin
        rq_dm = 1; rq_we = $urandom_range(0, 1) == 1;
        rq_da = ADDR_W'($urandom_range(0, 31)); rq_wd = $urandom;
      end else if (rq_dm && $urandom_range(0, 15) == 0) begin
        rq_dm = 0;
      end
      drive_cycle(rq_if, rq_ia, rq_dm, rq_we, rq_da, rq_wd);
      if (last_ig) rq_if = 0;
      if (last_dg) rq_dm = 0;
      if (i % 1000 == 500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
